alu_share_arbiter: RTL
======================

# alu_share_arbiter

Shares one ALU instance between up to NUM_REQ requesters, such as the integer pipeline, the address-generation path and the CSR/debug unit. Round-robin arbitration picks one requester per cycle and drives its operands and opcode into the ALU. The combinational result and all four flags are captured into a single response register, which is drained through a valid/ready handshake. Only this block instantiates the ALU.

## Interface
Parameters:
- NUM_REQ, default 2: number of requesters, 2..8.
- IDW, default $clog2(NUM_REQ): width of the requester id.

Ports:
- clk, in, 1: single clock; all state updates on its rising edge.
- rst_n, in, 1: asynchronous, active-low reset.
- req_valid, in, [NUM_REQ]: requester i has an operation pending.
- req_ready, out, [NUM_REQ]: requester i's operation is accepted this cycle.
- req_a, in, [NUM_REQ][XLEN]: source_a per requester.
- req_b, in, [NUM_REQ][XLEN]: source_b per requester.
- req_op, in, [NUM_REQ] alu_op_e: ALU operation per requester.
- req_lock, in, [NUM_REQ]: keep the grant after this beat. Used only when ALU_ARB_LOCK_EN is defined.
- rsp_valid, out, 1: response register holds a result.
- rsp_ready, in, 1: consumer takes the response.
- rsp_id, out, IDW: requester that issued the response.
- rsp_result, out, XLEN: captured alu_result.
- rsp_flags, out, 4: {overflow, carry, negative, zero}.

## Operation
- Response register states:
  - EMPTY: rsp_valid=0.
  - FULL: rsp_valid=1.
- can_accept = EMPTY | (FULL & rsp_ready).
- Grant:
  - One-hot grant to the first valid requester at or after rr_ptr, searching cyclically.
  - req_ready[i] = grant[i] & can_accept.
  - At most one req_ready is high per cycle.
- Accept: a beat is accepted when req_valid[i] & req_ready[i].
  - The granted a, b and op are muxed into the ALU.
  - The result, flags and id i are loaded into the response register.
  - The state goes to FULL.
- Drain: FULL & rsp_ready with no accept → EMPTY.
- Drain and accept in the same cycle: stay FULL with the new data, giving 1 op/cycle sustained.
- Hold: FULL & !rsp_ready:
  - All req_ready are 0.
  - rsp_* are held stable.
- rr_ptr update:
  - On accept from i, rr_ptr ← (i+1) mod NUM_REQ.
  - With no accept, rr_ptr is unchanged.
- Handshake rules:
  - A requester must hold valid, a, b and op stable until accepted.
  - req_valid must not depend on req_ready.
  - req_ready may depend combinationally on all req_valid and on rsp_ready.
- Ops not defined in alu_op_e pass through to the ALU default: result 0, zero=1.

## Timing
- Reset values:
  - rsp_valid=0, rsp_result=0, rsp_id=0, rsp_flags=0.
  - rr_ptr=0, lock inactive.
  - req_ready is 0 only while rst_n is low.
- Latency: accepted in cycle N → rsp_valid with data in cycle N+1.
- Throughput: one op per cycle while rsp_ready=1.
- Fairness: with all requesters valid, each is served within NUM_REQ accepts.
- Reset asserted mid-operation:
  - The response is discarded immediately.
  - No response is generated for a beat accepted in the same cycle reset asserts.
- No combinational path from req_* to rsp_*.

## Configuration
- Macro: ALU_ARB_LOCK_EN.
- Defined:
  - An accept from i with req_lock[i]=1 sets lock_owner=i.
  - While locked, only i can be granted, even if i is not valid (others wait).
  - The lock is released by an accept from i with req_lock[i]=0, or by reset.
  - rr_ptr still updates on each accept.
  - Use case: multi-op sequences such as compare-then-add.
- Undefined:
  - The req_lock port is still present and ignored.
  - No lock state is built.
  - Pure round-robin.

## Structure
- Shared package (riscv_pkg), already provided: XLEN and alu_op_e.
- New package constant: ALU_FLAG_W = 4.
- New package typedef: alu_flags_t, a packed struct {overflow, carry, negative, zero} used for rsp_flags.
- Sub-module rr_arbiter:
  - Parameterised by NUM_REQ.
  - Inputs: req vector, rr_ptr, lock/owner.
  - Outputs: one-hot grant and the encoded index.
- The alu is instantiated once inside this block.

## Test plan
- Reset then single op:
  - Stimulus: req 0 issues ADD a=5, b=7 with rsp_ready=1.
  - Response: next cycle rsp_valid=1, rsp_result=12, rsp_id=0, rsp_flags=0000.
- Contention:
  - Stimulus: both requesters hold valid continuously with rsp_ready=1. Req 0 issues SUB 3-3; req 1 issues XOR 0xF0^0x0F.
  - Response: grants alternate 0,1,0,1.
  - rsp 0 has result 0 and zero=1.
  - rsp 1 has result 0xFF.
- Backpressure:
  - Stimulus: rsp_ready=0 for 3 cycles after one accept.
  - Response: all req_ready=0 and rsp_* stable for those 3 cycles.
  - When rsp_ready rises, a new accept occurs in the same cycle.
- Flags:
  - Stimulus: ADD 0x7FFFFFFF+1.
  - Response: result 0x80000000, flags overflow=1, negative=1, carry=0, zero=0.
- Reset mid-stream:
  - Stimulus: assert rst_n=0 while FULL.
  - Response: rsp_valid falls to 0 asynchronously.
  - After release, the first grant goes to req 0.
- Lock (ALU_ARB_LOCK_EN defined):
  - Stimulus: req 1 issues SLT with lock=1, then SUB with lock=0, while req 0 is continuously valid.
  - Response: req 1 is granted twice back to back, then req 0.

Source files
------------

// File: rtl/alu_share_arbiter_pkg.sv
// rtl/alu_share_arbiter_pkg.sv - flag and response-register types for the shared ALU arbiter
package alu_share_arbiter_pkg;
  localparam int ALU_FLAG_W = 4;

  typedef struct packed {
    logic overflow;
    logic carry;
    logic negative;
    logic zero;
  } alu_flags_t;

  typedef enum logic {
    RSP_EMPTY = 1'b0,
    RSP_FULL  = 1'b1
  } rsp_state_e;
endpackage

// File: rtl/riscv_pkg.sv
// rtl/riscv_pkg.sv - shared core types: datapath width and ALU opcodes
package riscv_pkg;
  localparam int XLEN    = 32;
  localparam int SHAMT_W = $clog2(XLEN);

  typedef enum logic [3:0] {
    ALU_ADD  = 4'd0,
    ALU_SUB  = 4'd1,
    ALU_AND  = 4'd2,
    ALU_OR   = 4'd3,
    ALU_XOR  = 4'd4,
    ALU_SLL  = 4'd5,
    ALU_SRL  = 4'd6,
    ALU_SRA  = 4'd7,
    ALU_SLT  = 4'd8,
    ALU_SLTU = 4'd9
  } alu_op_e;
endpackage

// File: rtl/alu.sv
// rtl/alu.sv - combinational integer ALU with overflow/carry/negative/zero flags
// SUB reports carry as "no borrow" (a >= b unsigned).
module alu
  import riscv_pkg::*;
  import alu_share_arbiter_pkg::*;
(
  input  logic [XLEN-1:0]       a,
  input  logic [XLEN-1:0]       b,
  input  alu_op_e               op,
  output logic [XLEN-1:0]       result,
  output logic [ALU_FLAG_W-1:0] flags
);
  logic [XLEN:0]    sum;
  logic [SHAMT_W-1:0] shamt;
  logic             carry;
  logic             overflow;
  alu_flags_t       fl;

  assign shamt = b[SHAMT_W-1:0];

  always_comb begin
    sum      = '0;
    result   = '0;
    carry    = 1'b0;
    overflow = 1'b0;
    case (op)
      ALU_ADD: begin
        sum      = {1'b0, a} + {1'b0, b};
        result   = sum[XLEN-1:0];
        carry    = sum[XLEN];
        overflow = (a[XLEN-1] == b[XLEN-1]) && (result[XLEN-1] != a[XLEN-1]);
      end
      ALU_SUB: begin
        sum      = {1'b0, a} + {1'b0, ~b} + {{XLEN{1'b0}}, 1'b1};
        result   = sum[XLEN-1:0];
        carry    = sum[XLEN];
        overflow = (a[XLEN-1] != b[XLEN-1]) && (result[XLEN-1] != a[XLEN-1]);
      end
      ALU_AND:  result = a & b;
      ALU_OR:   result = a | b;
      ALU_XOR:  result = a ^ b;
      ALU_SLL:  result = a << shamt;
      ALU_SRL:  result = a >> shamt;
      ALU_SRA:  result = $signed(a) >>> shamt;
      ALU_SLT:  result = {{(XLEN-1){1'b0}}, $signed(a) < $signed(b)};
      ALU_SLTU: result = {{(XLEN-1){1'b0}}, a < b};
      default:  result = '0;
    endcase
  end

  always_comb begin
    fl.overflow = overflow;
    fl.carry    = carry;
    fl.negative = result[XLEN-1];
    fl.zero     = (result == '0);
  end

  assign flags = fl;
endmodule

// File: rtl/alu_share_arbiter_rr_arbiter.sv
// rtl/alu_share_arbiter_rr_arbiter.sv - cyclic round-robin grant with optional owner lock
module rr_arbiter #(
  parameter int NUM_REQ = 2,
  parameter int IDW     = $clog2(NUM_REQ)
) (
  input  logic [NUM_REQ-1:0] req,
  input  logic [IDW-1:0]     rr_ptr,
  input  logic               lock_active,
  input  logic [IDW-1:0]     lock_owner,
  output logic [NUM_REQ-1:0] grant,
  output logic [IDW-1:0]     grant_idx
);
  always_comb begin
    int   idx;
    logic found;
    idx       = 0;
    found     = 1'b0;
    grant     = '0;
    grant_idx = '0;
    // A locked owner keeps the grant even while it is not requesting.
    if (lock_active) begin
      grant[lock_owner] = 1'b1;
      grant_idx         = lock_owner;
    end else begin
      for (int off = 0; off < NUM_REQ; off++) begin
        idx = int'(rr_ptr) + off;
        if (idx >= NUM_REQ) idx = idx - NUM_REQ;
        if (!found && req[idx]) begin
          found      = 1'b1;
          grant[idx] = 1'b1;
          grant_idx  = IDW'(idx);
        end
      end
    end
  end
endmodule

// File: rtl/alu_share_arbiter.sv
// rtl/alu_share_arbiter.sv - round-robin sharing of one ALU with a registered valid/ready response
// Grant locking is built only when ALU_ARB_LOCK_EN is defined.
module alu_share_arbiter
  import riscv_pkg::*;
  import alu_share_arbiter_pkg::*;
#(
  parameter int NUM_REQ = 2,
  parameter int IDW     = $clog2(NUM_REQ)
) (
  input  logic                          clk,
  input  logic                          rst_n,
  input  logic [NUM_REQ-1:0]            req_valid,
  output logic [NUM_REQ-1:0]            req_ready,
  input  logic [NUM_REQ-1:0][XLEN-1:0]  req_a,
  input  logic [NUM_REQ-1:0][XLEN-1:0]  req_b,
  input  alu_op_e [NUM_REQ-1:0]         req_op,
  input  logic [NUM_REQ-1:0]            req_lock,
  output logic                          rsp_valid,
  input  logic                          rsp_ready,
  output logic [IDW-1:0]                rsp_id,
  output logic [XLEN-1:0]               rsp_result,
  output alu_flags_t                    rsp_flags
);
  rsp_state_e          state_q, state_d;
  logic [IDW-1:0]      rr_ptr_q, rr_ptr_d;
  logic [IDW-1:0]      rsp_id_q, rsp_id_d;
  logic [XLEN-1:0]     rsp_result_q, rsp_result_d;
  alu_flags_t          rsp_flags_q, rsp_flags_d;

  logic                lock_active;
  logic [IDW-1:0]      lock_owner;
  logic [NUM_REQ-1:0]  grant;
  logic [IDW-1:0]      grant_idx;
  logic                can_accept;
  logic                accept;
  logic [XLEN-1:0]     alu_result;
  logic [ALU_FLAG_W-1:0] alu_flags;

  rr_arbiter #(.NUM_REQ(NUM_REQ), .IDW(IDW)) u_rr_arbiter (
    .req         (req_valid),
    .rr_ptr      (rr_ptr_q),
    .lock_active (lock_active),
    .lock_owner  (lock_owner),
    .grant       (grant),
    .grant_idx   (grant_idx)
  );

  assign can_accept = (state_q == RSP_EMPTY) || rsp_ready;
  assign req_ready  = grant & {NUM_REQ{can_accept & rst_n}};
  assign accept     = |(req_valid & req_ready);

  alu u_alu (
    .a      (req_a[grant_idx]),
    .b      (req_b[grant_idx]),
    .op     (req_op[grant_idx]),
    .result (alu_result),
    .flags  (alu_flags)
  );

  always_comb begin
    state_d      = state_q;
    rr_ptr_d     = rr_ptr_q;
    rsp_id_d     = rsp_id_q;
    rsp_result_d = rsp_result_q;
    rsp_flags_d  = rsp_flags_q;
    // A drain and an accept in the same cycle simply overwrite the register.
    if (accept) begin
      state_d      = RSP_FULL;
      rsp_result_d = alu_result;
      rsp_flags_d  = alu_flags_t'(alu_flags);
      rsp_id_d     = grant_idx;
      rr_ptr_d     = (grant_idx == IDW'(NUM_REQ - 1)) ? '0 : grant_idx + 1'b1;
    end else if ((state_q == RSP_FULL) && rsp_ready) begin
      state_d = RSP_EMPTY;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q      <= RSP_EMPTY;
      rr_ptr_q     <= '0;
      rsp_id_q     <= '0;
      rsp_result_q <= '0;
      rsp_flags_q  <= '0;
    end else begin
      state_q      <= state_d;
      rr_ptr_q     <= rr_ptr_d;
      rsp_id_q     <= rsp_id_d;
      rsp_result_q <= rsp_result_d;
      rsp_flags_q  <= rsp_flags_d;
    end
  end

`ifdef ALU_ARB_LOCK_EN
  logic           lock_q, lock_d;
  logic [IDW-1:0] lock_owner_q, lock_owner_d;

  always_comb begin
    lock_d       = lock_q;
    lock_owner_d = lock_owner_q;
    if (accept) begin
      lock_d       = req_lock[grant_idx];
      lock_owner_d = grant_idx;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      lock_q       <= 1'b0;
      lock_owner_q <= '0;
    end else begin
      lock_q       <= lock_d;
      lock_owner_q <= lock_owner_d;
    end
  end

  assign lock_active = lock_q;
  assign lock_owner  = lock_owner_q;
`else
  logic unused_req_lock;
  assign unused_req_lock = ^req_lock;
  assign lock_active     = 1'b0;
  assign lock_owner      = '0;
`endif

  assign rsp_valid  = (state_q == RSP_FULL);
  assign rsp_id     = rsp_id_q;
  assign rsp_result = rsp_result_q;
  assign rsp_flags  = rsp_flags_q;
endmodule
